// File: rtl/dma_block_streamer_if.sv
// dma_block_streamer_if: DMA block-read port plus valid/ready word stream toward the PE array.
// The master modport is the streamer side; the slave modport is the DMA/PE side.
interface dma_block_streamer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int BLOCK_SIZE = 25
);
    logic                             dma_enable;
    logic                             dma_rw;
    logic [ADDR_WIDTH-1:0]            dma_address;
    logic [BLOCK_SIZE*DATA_WIDTH-1:0] dma_block;
    logic [DATA_WIDTH-1:0]            out_data;
    logic [4:0]                       out_index;
    logic                             out_valid;
    logic                             out_last;
    logic                             out_ready;

    modport master (
        output dma_enable, dma_rw, dma_address, out_data, out_index, out_valid, out_last,
        input  dma_block, out_ready
    );

    modport slave (
        input  dma_enable, dma_rw, dma_address, out_data, out_index, out_valid, out_last,
        output dma_block, out_ready
    );
endinterface

// File: rtl/dma_block_streamer.sv
// dma_block_streamer: fetch one 5x5 Q5.10 block over DMA and stream it word by word.
// Optional BLOCK_SUM_EN adds a saturated block sum reported in the DONE cycle.
module dma_block_streamer #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int BLOCK_SIZE   = 25,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    output logic                  busy_o,
    output logic                  done_o,
    dma_block_streamer_if.master  bus
`ifdef BLOCK_SUM_EN
    ,
    output logic [DATA_WIDTH-1:0] block_sum_o,
    output logic                  sum_valid_o
`endif
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, CAPTURE, STREAM, DONE} state_t;

    localparam logic [4:0] LAST      = 5'(BLOCK_SIZE - 1);
    localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0);

    state_t                state_q, state_d;
    logic [4:0]            idx_q, idx_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] mem_q [BLOCK_SIZE];
    logic                  hs;

    assign hs              = (state_q == STREAM) && bus.out_ready;
    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == DONE);
    assign bus.dma_enable  = (state_q == REQ);
    assign bus.dma_rw      = (state_q == REQ);
    assign bus.dma_address = addr_q;
    assign bus.out_valid   = (state_q == STREAM);
    assign bus.out_data    = (state_q == STREAM) ? mem_q[idx_q] : '0;
    assign bus.out_index   = (state_q == STREAM) ? idx_q : '0;
    assign bus.out_last    = (state_q == STREAM) && (idx_q == LAST);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: if (start_i) begin
                addr_d  = base_addr_i;
                state_d = REQ;
            end
            REQ: begin
                cnt_d   = '0;
                state_d = (READ_LATENCY > 1) ? WAIT : CAPTURE;
            end
            WAIT: begin
                cnt_d   = cnt_q + 2'd1;
                state_d = (cnt_q == WAIT_LAST) ? CAPTURE : WAIT;
            end
            CAPTURE: begin
                idx_d   = '0;
                state_d = STREAM;
            end
            STREAM: if (hs) begin
                idx_d   = (idx_q == LAST) ? '0 : idx_q + 5'd1;
                state_d = (idx_q == LAST) ? DONE : STREAM;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    // Buffer contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk) begin
        if (state_q == CAPTURE)
            for (int k = 0; k < BLOCK_SIZE; k++)
                mem_q[k] <= bus.dma_block[k*DATA_WIDTH +: DATA_WIDTH];
    end

`ifdef BLOCK_SUM_EN
    localparam int ACC_W = DATA_WIDTH + 5;
    localparam logic signed [ACC_W-1:0] SMAX = {6'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

    logic signed [ACC_W-1:0] acc_q;
    logic [DATA_WIDTH-1:0]   sum_q, sat;
    logic [DATA_WIDTH-1:0]   w;

    assign w           = mem_q[idx_q];
    assign sat         = (acc_q > SMAX) ? SMAX[DATA_WIDTH-1:0] :
                         (acc_q < SMIN) ? SMIN[DATA_WIDTH-1:0] : acc_q[DATA_WIDTH-1:0];
    assign block_sum_o = (state_q == DONE) ? sat : sum_q;
    assign sum_valid_o = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            sum_q <= '0;
        end else begin
            if (state_q == CAPTURE) acc_q <= '0;
            else if (hs) acc_q <= acc_q + {{5{w[DATA_WIDTH-1]}}, w};
            if (state_q == DONE) sum_q <= sat;
        end
    end
`endif
endmodule

// File: tb/tb_dma_block_streamer.sv
// tb_dma_block_streamer: table of block transfers checked against a word-list model.
module tb_dma_block_streamer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [15:0] base_addr_i;
    logic        busy_o, done_o;
`ifdef BLOCK_SUM_EN
    logic [15:0] block_sum_o;
    logic        sum_valid_o;
`endif
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dma_block_streamer_if ifc ();

    dma_block_streamer dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
        .busy_o(busy_o), .done_o(done_o), .bus(ifc.master)
`ifdef BLOCK_SUM_EN
        , .block_sum_o(block_sum_o), .sum_valid_o(sum_valid_o)
`endif
    );

    typedef struct {
        logic [15:0] addr;
        int kind;      // 0: all 0x0400, 1: k*0x0100, 2: random, 3: all 0x7000
        int rdy;       // 0: always, 1: toggle, 2: random
        int exp_done;  // cycle of done after start edge, -1 = not fixed
        bit corrupt;
        bit restart;
        int abort;     // handshakes before async reset, -1 = none
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy_o), 0);
        chk({tag, "_done"}, 32'(done_o), 0);
        chk({tag, "_en"}, 32'(ifc.dma_enable), 0);
        chk({tag, "_rw"}, 32'(ifc.dma_rw), 0);
        chk({tag, "_addr"}, 32'(ifc.dma_address), 0);
        chk({tag, "_valid"}, 32'(ifc.out_valid), 0);
        chk({tag, "_last"}, 32'(ifc.out_last), 0);
        chk({tag, "_data"}, 32'(ifc.out_data), 0);
        chk({tag, "_index"}, 32'(ifc.out_index), 0);
    endtask

    task automatic run(input vec_t v);
        logic [15:0] w [25];
        int hs = 0;
        int done_t = -1;
        int sum = 0;
        logic r;
        for (int k = 0; k < 25; k++) begin
            w[k] = (v.kind == 0) ? 16'h0400 : (v.kind == 1) ? 16'(k * 256) :
                   (v.kind == 3) ? 16'h7000 : 16'($urandom);
            ifc.dma_block[k*16 +: 16] = w[k];
            sum += int'($signed(w[k]));
        end
        sum = (sum > 32767) ? 32767 : (sum < -32768) ? -32768 : sum;
        start_i = 1'b1;
        base_addr_i = v.addr;
        step();
        start_i = 1'b0;
        base_addr_i = 16'($urandom);
        for (int t = 1; t < 400 && done_t < 0; t++) begin
            if (v.abort >= 0 && hs == v.abort) begin
                rst_n = 1'b0;
                #1;
                chk_zero("abort");
                step();
                step();
                rst_n = 1'b1;
                return;
            end
            if (v.corrupt && t == 3) ifc.dma_block = '1;
            start_i = v.restart && t == 10;
            r = (v.rdy == 0) ? 1'b1 : (v.rdy == 1) ? t[0] : 1'($urandom);
            ifc.out_ready = r;
            #1;
            chk("dma_enable", 32'(ifc.dma_enable), 32'(t == 1));
            chk("dma_rw", 32'(ifc.dma_rw), 32'(t == 1));
            if (t == 1) chk("dma_address", 32'(ifc.dma_address), 32'(v.addr));
            chk("busy", 32'(busy_o), 1);
            chk("out_valid", 32'(ifc.out_valid), 32'(t >= 3 && hs < 25));
            if (ifc.out_valid) begin
                chk("out_data", 32'(ifc.out_data), 32'(w[hs]));
                chk("out_index", 32'(ifc.out_index), 32'(hs));
                chk("out_last", 32'(ifc.out_last), 32'(hs == 24));
            end
            if (ifc.out_valid && r) hs++;
            if (done_o) begin
                done_t = t;
                chk("done_handshakes", 32'(hs), 25);
                if (v.exp_done >= 0) chk("done_cycle", 32'(t), 32'(v.exp_done));
`ifdef BLOCK_SUM_EN
                chk("sum_valid", 32'(sum_valid_o), 1);
                chk("block_sum", 32'(block_sum_o), 32'(16'(sum)));
`endif
            end
            step();
        end
        if (done_t < 0) chk("timeout", 0, 1);
        start_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("post_busy", 32'(busy_o), 0);
            chk("post_done", 32'(done_o), 0);
            chk("post_en", 32'(ifc.dma_enable), 0);
            chk("post_valid", 32'(ifc.out_valid), 0);
`ifdef BLOCK_SUM_EN
            chk("post_sum_valid", 32'(sum_valid_o), 0);
            chk("post_sum_hold", 32'(block_sum_o), 32'(16'(sum)));
`endif
            step();
        end
    endtask

    initial begin
        vec_t vt [11];
        vt[0]  = '{16'h0040, 0, 0, 28, 0, 0, -1};
        vt[1]  = '{16'h1234, 1, 1, 52, 0, 0, -1};
        vt[2]  = '{16'h0100, 1, 0, 28, 1, 0, -1};
        vt[3]  = '{16'h0200, 2, 2, -1, 0, 1, -1};
        vt[4]  = '{16'h0300, 2, 0, 28, 0, 0, 10};
        vt[5]  = '{16'h0400, 0, 0, 28, 0, 0, -1};
        vt[6]  = '{16'h0500, 3, 0, 28, 0, 0, -1};
        for (int i = 7; i < 11; i++) vt[i] = '{16'($urandom), 2, 2, -1, 0, 0, -1};
        rst_n = 1'b0;
        start_i = 1'b0;
        base_addr_i = 16'h0;
        ifc.out_ready = 1'b1;
        ifc.dma_block = '0;
        step();
        step();
        chk_zero("reset");
`ifdef BLOCK_SUM_EN
        chk("reset_sum", 32'(block_sum_o), 0);
        chk("reset_sum_valid", 32'(sum_valid_o), 0);
`endif
        rst_n = 1'b1;
        step();
        chk_zero("idle");
        for (int i = 0; i < 11; i++) run(vt[i]);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dma_block_streamer.md
Name: dma_block_streamer

Overview:
- Downstream consumer of the DMA block-read port.
- On `start`, issues one DMA read request, captures the returned 25-word (5x5) block of signed Q5.10 data into a local register file, and streams the words one per handshake to the convolution PE array over a valid/ready interface.
- Also provides start/busy/done control toward the layer sequencer.

Parameters:
- DATA_WIDTH, 16, width of one block word (signed Q5.10).
- ADDR_WIDTH, 16, DMA address width.
- BLOCK_SIZE, 25, words per DMA block.
- READ_LATENCY, 1, cycles from the DMA request cycle to the cycle in which `dma_block` is valid and sampled (1..4).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: fetch and stream one block; honoured only in IDLE.
- base_addr  in  ADDR_WIDTH  block base address; latched on accepted start.
- busy  out  1  high from accepted start until DONE exits.
- done  out  1  one-cycle pulse after the last word handshakes.
- dma_enable  out  1  DMA enable.
- dma_rw  out  1  DMA direction; 1 = read.
- dma_address  out  ADDR_WIDTH  latched base_addr.
- dma_block  in  BLOCK_SIZE*DATA_WIDTH  flattened DMA output; word k is at [k*DATA_WIDTH +: DATA_WIDTH].
- out_data  out  DATA_WIDTH  current streamed word.
- out_index  out  5  index of out_data (0..BLOCK_SIZE-1).
- out_valid  out  1  out_data valid.
- out_last  out  1  high with the valid word at index BLOCK_SIZE-1.
- out_ready  in  1  PE accepts the word when out_valid & out_ready.

Behaviour:
- Reset (async, rst_n=0): state IDLE. busy, done, dma_enable, dma_rw, out_valid and out_last are 0. out_data, out_index and dma_address are 0. The buffer contents are don't-care.
- FSM: IDLE -> REQ -> WAIT -> CAPTURE -> STREAM -> DONE -> IDLE.
- IDLE: start=1 latches base_addr and goes to REQ. start in any other state is ignored (no queueing).
- REQ (1 cycle): dma_enable=1, dma_rw=1, dma_address=latched address. Then go to WAIT.
- dma_enable and dma_rw are 0 in every state except REQ. The block never issues DMA writes.
- WAIT: counts READ_LATENCY-1 cycles; this is 0 cycles when READ_LATENCY=1, so the FSM passes directly to CAPTURE.
- CAPTURE (1 cycle): all BLOCK_SIZE words are registered from dma_block in parallel. Index counter is cleared. Go to STREAM.
- STREAM: out_valid=1, out_data=buf[idx], out_index=idx, out_last=(idx==BLOCK_SIZE-1).
  - Handshake (valid & ready): idx increments. On the last word, go to DONE.
  - No handshake: out_data, out_index and out_last are held stable. out_valid never drops once raised until the last word is accepted.
- DONE (1 cycle): done=1, out_valid=0, busy=1. Next state IDLE, where busy=0.
- Latency, READ_LATENCY=1, ready tied high:
  - start sampled at edge 0; REQ in cycle 1; CAPTURE in cycle 2.
  - First out_valid in cycle 3; last word in cycle 27; done in cycle 28.
  - Total throughput: one block per 29 cycles including IDLE.
- Data is passed through bit-exact; no arithmetic on the streamed path.
- Changes on dma_block after CAPTURE have no effect on streamed data.
- rst_n asserted mid-operation (any state) returns immediately to IDLE with reset output values. A partially streamed block is discarded; no done pulse.
- out_ready is ignored outside STREAM.

Optional Feature:
- Macro: BLOCK_SUM_EN.
- When defined: extra outputs `block_sum` (DATA_WIDTH, signed Q5.10) and `sum_valid` (1).
  - During STREAM, each handshaken word is accumulated in a DATA_WIDTH+5 bit signed accumulator, cleared in CAPTURE.
  - In DONE, block_sum = accumulator saturated to [0x8000, 0x7FFF], with sum_valid=1 for that one cycle.
  - Both outputs are 0 at reset and otherwise hold their last value; sum_valid is 0 outside DONE.
- When undefined: ports and accumulator are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then start with base_addr=0x0040 and dma_block all words 0x0400, out_ready=1 -> dma_enable=dma_rw=1 for exactly one cycle with dma_address=0x0040; 25 words of 0x0400 with indices 0..24; out_last only on 24; done pulses in cycle 28.
- dma_block word k = k*0x0100, out_ready toggling 1,0,1,0 -> words emitted in order 0x0000..0x1800; data, index and valid held during ready=0 cycles; exactly 25 handshakes.
- dma_block changed to 0xFFFF one cycle after CAPTURE -> streamed words still equal the captured values.
- start pulsed again during STREAM -> ignored; only one dma_enable pulse and one done per block.
- rst_n asserted after 10 handshakes -> all outputs 0 immediately; a new start afterwards streams a full 25-word block.
- BLOCK_SUM_EN defined, all words 0x0400 -> block_sum=0x6400 (25.0) with sum_valid in DONE. All words 0x7000 -> block_sum saturates to 0x7FFF.
